// File: rtl/store_write_buffer.sv
// store_write_buffer
//   Posted-write FIFO sitting between the core's data-memory port and a slow
//   data memory. The core hands over each store in a single cycle. The buffer
//   then drains the stores to memory in order over a valid/ready handshake.
//   While stores are still pending, a load whose address hits one of them gets
//   the buffered data forwarded, so the core never reads stale memory.
//
// Ports
//   clk        clock; all state updates on the rising edge
//   reset      asynchronous reset, active low
//   memwrite   store strobe from the core (one per store instruction)
//   memread    load strobe from the core
//   dataadr    byte address from the core; loads and stores share it
//   writedata  store data from the core
//   stall      the store was not accepted; the core holds the instruction
//   fwd_hit    the load address matches a pending entry
//   fwd_data   data of the youngest matching entry; 0 when there is no hit
//   mem_valid  the head entry is presented to memory
//   mem_addr   address of the head entry (word aligned)
//   mem_wdata  data of the head entry
//   mem_ready  memory takes the head entry when mem_valid is also high
//   count      number of occupied entries
//   empty      count == 0

module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memwrite,
  input  logic                     memread,
  input  logic [AW-1:0]            dataadr,
  input  logic [DW-1:0]            writedata,
  output logic                     stall,
  output logic                     fwd_hit,
  output logic [DW-1:0]            fwd_data,
  output logic                     mem_valid,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  input  logic                     mem_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;

  logic full;
  logic deq;
  logic enq;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // Head outputs come straight from registered storage. They therefore stay
  // stable for as long as memory holds off mem_ready.
  assign mem_valid = !empty;
  assign mem_addr  = addr_q[rd_ptr];
  assign mem_wdata = data_q[rd_ptr];

  assign deq = mem_valid & mem_ready;
  // A full buffer can still take a store in the same cycle that the head drains.
  assign enq   = memwrite & (!full | deq);
  assign stall = memwrite & full & !deq;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (enq) begin
        addr_q[wr_ptr] <= {dataadr[AW-1:2], 2'b00};
        data_q[wr_ptr] <= writedata;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({enq, deq})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Walk the occupied entries from oldest to youngest, so the last match seen
  // is the youngest one. A head entry that is draining this cycle is still
  // occupied and therefore still forwards.
  logic [PW-1:0] idx;

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    if (memread && !memwrite) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr + PW'(i);
        if ((CW'(i) < count_q) && (addr_q[idx][AW-1:2] == dataadr[AW-1:2])) begin
          fwd_hit  = 1'b1;
          fwd_data = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
module tb_store_write_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite, memread, mem_ready;
  logic [31:0] dataadr, writedata;
  logic        stall, fwd_hit, mem_valid, empty;
  logic [31:0] fwd_data, mem_addr, mem_wdata;
  logic [2:0]  count;

  store_write_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .memread(memread),
    .dataadr(dataadr), .writedata(writedata), .stall(stall),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .mem_valid(mem_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
  ent_t        q[$];
  logic [31:0] drained[$];
  logic [31:0] gold[logic [31:0]];
  logic [31:0] mem_img[logic [31:0]];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          enq_total = 0;
  bit          last_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs already driven at the negedge. Check against the
  // queue model, then advance the model at the posedge.
  task automatic step();
    int   n;
    bit   deq, enq, exp_hit;
    logic [31:0] exp_fd;
    #1;
    n       = q.size();
    deq     = (n > 0) && mem_ready;
    enq     = memwrite && ((n < DEPTH) || deq);
    exp_hit = 1'b0;
    exp_fd  = '0;
    if (memread && !memwrite)
      for (int i = 0; i < n; i++)
        if (q[i].a[31:2] == dataadr[31:2]) begin
          exp_hit = 1'b1;
          exp_fd  = q[i].d;
        end
    last_stall = memwrite && !enq;
    chk("stall", stall, last_stall);
    chk("fwd_hit", fwd_hit, exp_hit);
    chk("fwd_data", fwd_data, exp_fd);
    chk("count", count, n);
    chk("empty", empty, n == 0);
    chk("mem_valid", mem_valid, n > 0);
    if (n > 0) begin
      chk("mem_addr", mem_addr, q[0].a);
      chk("mem_wdata", mem_wdata, q[0].d);
    end
    if (mem_valid && mem_ready) begin
      mem_img[mem_addr] = mem_wdata;
      drained.push_back(mem_wdata);
    end
    @(posedge clk);
    if (deq) void'(q.pop_front());
    if (enq) begin
      q.push_back('{{dataadr[31:2], 2'b00}, writedata});
      gold[{dataadr[31:2], 2'b00}] = writedata;
      enq_total++;
    end
    @(negedge clk);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; memread = 1'b0; dataadr = a; writedata = d;
    step();
    memwrite = 1'b0;
  endtask

  task automatic drain();
    memwrite = 1'b0; memread = 1'b0; mem_ready = 1'b1;
    for (int k = 0; k < 8 && q.size() > 0; k++) step();
    chk("drain_empty", empty, 1'b1);
    mem_ready = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_valid"}, mem_valid, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    int held, n_drained;
    reset = 1'b0; memwrite = 1'b0; memread = 1'b0; mem_ready = 1'b0;
    dataadr = '0; writedata = '0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_state("rst0");
    chk("rst0_stall", stall, 0);
    chk("rst0_fwd", fwd_hit, 0);
    reset = 1'b1;
    @(negedge clk);

    // 1: reset in the middle of a drain
    store(32'h10, 32'hA1);
    store(32'h14, 32'hA2);
    store(32'h18, 32'hA3);
    mem_ready = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check_reset_state("rst1");
    repeat (2) @(negedge clk);
    q.delete();
    reset = 1'b1;
    n_drained = drained.size();
    repeat (3) step();
    chk("rst1_no_handshake", drained.size(), n_drained);
    mem_ready = 1'b0;

    // 2: single store latency and drain
    store(32'h54, 32'd7);
    #1;
    chk("t2_valid", mem_valid, 1);
    chk("t2_addr", mem_addr, 32'h54);
    chk("t2_wdata", mem_wdata, 32'd7);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    #1;
    chk("t2_empty", empty, 1);
    step();

    // 3: fill, stall, accept-on-drain, order
    drained.delete();
    for (int d = 1; d <= 4; d++) store(32'h100 + 32'(4 * (d - 1)), 32'(d));
    memwrite = 1'b1; dataadr = 32'h110; writedata = 32'd5;
    #1;
    chk("t3_stall5", stall, 1);
    chk("t3_count", count, 4);
    step();
    mem_ready = 1'b1;
    #1;
    chk("t3_accept", stall, 0);
    step();
    memwrite = 1'b0; mem_ready = 1'b0;
    #1;
    chk("t3_count_kept", count, 4);
    drain();
    chk("t3_ndrained", drained.size(), 5);
    for (int i = 0; i < 5 && i < drained.size(); i++) chk("t3_order", drained[i], 32'(i + 1));

    // 4: youngest match wins, word compare
    store(32'h60, 32'd3);
    store(32'h60, 32'd9);
    memread = 1'b1; dataadr = 32'h62;
    #1;
    chk("t4_hit", fwd_hit, 1);
    chk("t4_data", fwd_data, 32'd9);
    step();
    dataadr = 32'h64;
    #1;
    chk("t4_miss", fwd_hit, 0);
    step();
    drain();

    // 5: the draining head still forwards
    store(32'h20, 32'd5);
    memread = 1'b1; dataadr = 32'h20; mem_ready = 1'b1;
    #1;
    chk("t5_hit", fwd_hit, 1);
    chk("t5_data", fwd_data, 32'd5);
    step();
    #1;
    chk("t5_gone", fwd_hit, 0);
    step();
    memread = 1'b0; mem_ready = 1'b0;

    // 6: random traffic against a golden memory image
    gold.delete(); mem_img.delete(); enq_total = 0; last_stall = 1'b0;
    held = 0;
    for (int c = 0; c < 800; c++) begin
      if (!last_stall) begin
        memwrite  = ($urandom_range(0, 2) == 0);
        dataadr   = 32'h200 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
        writedata = $urandom;
      end else held++;
      memread   = !memwrite && ($urandom_range(0, 1) == 1);
      mem_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    drain();
    foreach (gold[a]) chk("t6_mem_img", mem_img.exists(a) ? mem_img[a] : 32'hDEAD_BEEF, gold[a]);
    chk("t6_wrap", enq_total >= 2 * DEPTH + 1, 1);
    chk("t6_stalls_seen", held > 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
